// File: rtl/sram_axi_bridge_n_pkg.sv
// Shared constants and types for the parametrised SRAM-like to AXI3 bridge.
package sram_axi_bridge_n_pkg;

   // AXI3 burst/length encodings used for single-beat transfers
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [7:0] LEN_SINGLE = 8'd0;

   // SRAM-like size encodings (bytes = 1 << size)
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // Arbitration modes
   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   // Write channel state: address/data phase, then waiting for B
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   // SRAM size to AXI AxSIZE
   function automatic logic [2:0] axi_size(input logic [1:0] s);
      return {1'b0, s};
   endfunction

endpackage

// File: rtl/sram_axi_bridge_n_arbiter.sv
// One-hot grant among eligible ports: fixed priority (port 0 first) or
// round-robin starting at the pointer held by the parent.
module sram_axi_arbiter
   import sram_axi_bridge_n_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic          mode_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o
);

   logic found;

   // First pass covers ports at/after the pointer (all ports in fixed mode),
   // second pass wraps around to the ports below the pointer.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i] && (mode_i == ARB_FIXED || i >= int'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_axi_bridge_n.sv
// NUM_PORTS SRAM-like masters onto one AXI3 master: one outstanding read per
// port plus one write, with same-word read/write hazard blocking.
module sram_axi_bridge_n
   import sram_axi_bridge_n_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int ARB_MODE  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_PORTS-1:0]    sram_req,
   input  logic [NUM_PORTS-1:0]    sram_wr,
   input  logic [2*NUM_PORTS-1:0]  sram_size,
   input  logic [4*NUM_PORTS-1:0]  sram_wstrb,
   input  logic [32*NUM_PORTS-1:0] sram_addr,
   input  logic [32*NUM_PORTS-1:0] sram_wdata,
   output logic [NUM_PORTS-1:0]    sram_addr_ok,
   output logic [NUM_PORTS-1:0]    sram_data_ok,
   output logic [32*NUM_PORTS-1:0] sram_rdata,
   output logic [3:0]              m_arid,
   output logic [31:0]             m_araddr,
   output logic [7:0]              m_arlen,
   output logic [2:0]              m_arsize,
   output logic [1:0]              m_arburst,
   output logic [1:0]              m_arlock,
   output logic [3:0]              m_arcache,
   output logic [2:0]              m_arprot,
   output logic                    m_arvalid,
   input  logic                    m_arready,
   input  logic [3:0]              m_rid,
   input  logic [31:0]             m_rdata,
   input  logic [1:0]              m_rresp,
   input  logic                    m_rlast,
   input  logic                    m_rvalid,
   output logic                    m_rready,
   output logic [3:0]              m_awid,
   output logic [31:0]             m_awaddr,
   output logic [7:0]              m_awlen,
   output logic [2:0]              m_awsize,
   output logic [1:0]              m_awburst,
   output logic [1:0]              m_awlock,
   output logic [3:0]              m_awcache,
   output logic [2:0]              m_awprot,
   output logic                    m_awvalid,
   input  logic                    m_awready,
   output logic [3:0]              m_wid,
   output logic [31:0]             m_wdata,
   output logic [3:0]              m_wstrb,
   output logic                    m_wlast,
   output logic                    m_wvalid,
   input  logic                    m_wready,
   input  logic [3:0]              m_bid,
   input  logic [1:0]              m_bresp,
   input  logic                    m_bvalid,
   output logic                    m_bready
);

   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // Per-port views of the flat request buses
   logic [NUM_PORTS-1:0][31:0] addr_a, wdata_a;
   logic [NUM_PORTS-1:0][3:0]  wstrb_a;
   logic [NUM_PORTS-1:0][1:0]  size_a;
   assign addr_a  = sram_addr;
   assign wdata_a = sram_wdata;
   assign wstrb_a = sram_wstrb;
   assign size_a  = sram_size;

   // Read tracking
   logic [NUM_PORTS-1:0]       rd_busy_q, rd_busy_d, r_hit;
   logic [NUM_PORTS-1:0][29:0] rd_addr_q;
   logic [NUM_PORTS-1:0][31:0] rdata_q;
   logic [NUM_PORTS-1:0]       data_ok_q, data_ok_d;
   logic                       arvalid_q;
   logic [3:0]                 arid_q;
   logic [31:0]                araddr_q;
   logic [2:0]                 arsize_q;

   // Write tracking
   wr_state_e                  w_state_q, w_state_d;
   logic                       awvalid_q, awvalid_d, wvalid_q, wvalid_d, w_done;
   logic [PW-1:0]              w_owner_q;
   logic [29:0]                w_addr_q;
   logic [31:0]                awaddr_q, wdata_q;
   logic [2:0]                 awsize_q;
   logic [3:0]                 awid_q, wstrb_q;

   // Arbitration
   logic [NUM_PORTS-1:0]       rd_elig, wr_elig, rd_hit, wr_hit, gnt;
   logic [PW-1:0]              ptr_q, ptr_d, g_idx;
   logic                       g_any, g_wr;
   logic [31:0]                g_addr, g_wdata;
   logic [3:0]                 g_wstrb;
   logic [1:0]                 g_size;

   // Eligibility: reads wait for a free AR slot and no in-flight write to the
   // same word; writes wait for an idle write channel and no pending read of
   // the same word.
   always_comb begin
      rd_elig = '0;
      wr_elig = '0;
      rd_hit  = '0;
      wr_hit  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int q = 0; q < NUM_PORTS; q++) begin
            if (rd_busy_q[q] && rd_addr_q[q] == addr_a[p][31:2]) rd_hit[p] = 1'b1;
         end
         wr_hit[p]  = (w_state_q != W_IDLE) && (addr_a[p][31:2] == w_addr_q);
         rd_elig[p] = sram_req[p] & ~sram_wr[p] & ~rd_busy_q[p] & ~arvalid_q & ~wr_hit[p];
         wr_elig[p] = sram_req[p] & sram_wr[p] & (w_state_q == W_IDLE) & ~rd_hit[p];
      end
   end

   sram_axi_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
      .req_i  (rd_elig | wr_elig),
      .mode_i ((ARB_MODE != 0) ? ARB_RR : ARB_FIXED),
      .ptr_i  (ptr_q),
      .gnt_o  (gnt)
   );

   // addr_ok must read low while reset is held, even with requests pending
   assign sram_addr_ok = gnt & {NUM_PORTS{rst_n}};

   // Select the granted port's request fields and advance the RR pointer
   always_comb begin
      g_any   = |gnt;
      g_wr    = |(gnt & sram_wr);
      g_idx   = '0;
      g_addr  = '0;
      g_wdata = '0;
      g_wstrb = '0;
      g_size  = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (gnt[p]) begin
            g_idx   = PW'(p);
            g_addr  = addr_a[p];
            g_wdata = wdata_a[p];
            g_wstrb = wstrb_a[p];
            g_size  = size_a[p];
         end
      end
      ptr_d = ptr_q;
      if (g_any) ptr_d = (int'(g_idx) == NUM_PORTS - 1) ? '0 : g_idx + 1'b1;
   end

   // Per-port read busy/response routing and data_ok pulse generation
   always_comb begin
      rd_busy_d = rd_busy_q;
      data_ok_d = '0;
      r_hit     = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (m_rvalid && m_rid == 4'(p) && rd_busy_q[p]) begin
            r_hit[p]     = 1'b1;
            rd_busy_d[p] = 1'b0;
            data_ok_d[p] = 1'b1;
         end
         if (gnt[p] && !g_wr) rd_busy_d[p] = 1'b1;
         if (w_done && w_owner_q == PW'(p)) data_ok_d[p] = 1'b1;
      end
   end

   // Read-side state: busy flags, pending word addresses, returned data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_busy_q <= '0;
         rd_addr_q <= '0;
         rdata_q   <= '0;
         data_ok_q <= '0;
         ptr_q     <= '0;
      end else begin
         rd_busy_q <= rd_busy_d;
         data_ok_q <= data_ok_d;
         ptr_q     <= ptr_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_hit[p]) rdata_q[p] <= m_rdata;
            if (gnt[p] && !g_wr) rd_addr_q[p] <= addr_a[p][31:2];
         end
      end
   end

   // AR channel: load on a read grant, hold until arready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arvalid_q <= 1'b0;
         arid_q    <= '0;
         araddr_q  <= '0;
         arsize_q  <= '0;
      end else if (g_any && !g_wr) begin
         arvalid_q <= 1'b1;
         arid_q    <= 4'(g_idx);
         araddr_q  <= g_addr;
         arsize_q  <= axi_size(g_size);
      end else if (arvalid_q && m_arready) begin
         arvalid_q <= 1'b0;
      end
   end

   // Write FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
      end
   end

   // Write FSM next state: AW and W retire independently, then wait for B
   always_comb begin
      w_state_d = w_state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      w_done    = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (g_any && g_wr) begin
               w_state_d = W_ADDR;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
            end
         end
         W_ADDR: begin
            if (awvalid_q && m_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) w_state_d = W_RESP;
         end
         W_RESP: begin
            if (m_bvalid) begin
               w_state_d = W_IDLE;
               w_done    = 1'b1;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Latch the write request payload at grant time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_owner_q <= '0;
         w_addr_q  <= '0;
         awid_q    <= '0;
         awaddr_q  <= '0;
         awsize_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else if (w_state_q == W_IDLE && g_any && g_wr) begin
         w_owner_q <= g_idx;
         w_addr_q  <= g_addr[31:2];
         awid_q    <= 4'(g_idx);
         awaddr_q  <= g_addr;
         awsize_q  <= axi_size(g_size);
         wdata_q   <= g_wdata;
         wstrb_q   <= g_wstrb;
      end
   end

   assign sram_data_ok = data_ok_q;
   assign sram_rdata   = rdata_q;

   assign m_arid    = arid_q;
   assign m_araddr  = araddr_q;
   assign m_arlen   = LEN_SINGLE;
   assign m_arsize  = arsize_q;
   assign m_arburst = BURST_INCR;
   assign m_arlock  = '0;
   assign m_arcache = '0;
   assign m_arprot  = '0;
   assign m_arvalid = arvalid_q;
   assign m_rready  = 1'b1;

   assign m_awid    = awid_q;
   assign m_awaddr  = awaddr_q;
   assign m_awlen   = LEN_SINGLE;
   assign m_awsize  = awsize_q;
   assign m_awburst = BURST_INCR;
   assign m_awlock  = '0;
   assign m_awcache = '0;
   assign m_awprot  = '0;
   assign m_awvalid = awvalid_q;

   assign m_wid     = awid_q;
   assign m_wdata   = wdata_q;
   assign m_wstrb   = wstrb_q;
   assign m_wlast   = 1'b1;
   assign m_wvalid  = wvalid_q;
   assign m_bready  = 1'b1;

   // Response status and B id carry nothing the bridge acts on
   logic unused_resp;
   assign unused_resp = ^{m_rresp, m_rlast, m_bid, m_bresp};

endmodule

// File: tb/tb_sram_axi_bridge_n.sv
// Directed bench: a round-robin instance (main checks) and a fixed-priority
// instance sharing the same stimulus, used where arbitration order differs.
module tb_sram_axi_bridge_n;
   import sram_axi_bridge_n_pkg::*;

   localparam int N = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Shared stimulus
   logic [N-1:0]    req, wr;
   logic [2*N-1:0]  size;
   logic [4*N-1:0]  wstrb;
   logic [32*N-1:0] addr, wdata;
   logic            m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid;
   logic [3:0]      m_rid, m_bid;
   logic [31:0]     m_rdata;
   logic [1:0]      m_rresp, m_bresp;

   // Round-robin instance outputs
   logic [N-1:0]    addr_ok, data_ok;
   logic [32*N-1:0] srdata;
   logic [3:0]      m_arid, m_awid, m_wid, m_arcache, m_awcache, m_wstrb;
   logic [31:0]     m_araddr, m_awaddr, m_wdata;
   logic [7:0]      m_arlen, m_awlen;
   logic [2:0]      m_arsize, m_awsize, m_arprot, m_awprot;
   logic [1:0]      m_arburst, m_awburst, m_arlock, m_awlock;
   logic            m_arvalid, m_awvalid, m_wvalid, m_wlast, m_rready, m_bready;

   // Fixed-priority instance outputs
   logic [N-1:0]    f_addr_ok, f_data_ok;
   logic [32*N-1:0] f_srdata;
   logic [3:0]      f_arid, f_awid, f_wid, f_arcache, f_awcache, f_wstrb;
   logic [31:0]     f_araddr, f_awaddr, f_wdata;
   logic [7:0]      f_arlen, f_awlen;
   logic [2:0]      f_arsize, f_awsize, f_arprot, f_awprot;
   logic [1:0]      f_arburst, f_awburst, f_arlock, f_awlock;
   logic            f_arvalid, f_awvalid, f_wvalid, f_wlast, f_rready, f_bready;

   sram_axi_bridge_n #(.NUM_PORTS(N), .ARB_MODE(1)) u_rr (
      .clk(clk), .rst_n(rst_n), .sram_req(req), .sram_wr(wr), .sram_size(size),
      .sram_wstrb(wstrb), .sram_addr(addr), .sram_wdata(wdata),
      .sram_addr_ok(addr_ok), .sram_data_ok(data_ok), .sram_rdata(srdata),
      .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
      .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
      .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
      .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   sram_axi_bridge_n #(.NUM_PORTS(N), .ARB_MODE(0)) u_fx (
      .clk(clk), .rst_n(rst_n), .sram_req(req), .sram_wr(wr), .sram_size(size),
      .sram_wstrb(wstrb), .sram_addr(addr), .sram_wdata(wdata),
      .sram_addr_ok(f_addr_ok), .sram_data_ok(f_data_ok), .sram_rdata(f_srdata),
      .m_arid(f_arid), .m_araddr(f_araddr), .m_arlen(f_arlen), .m_arsize(f_arsize),
      .m_arburst(f_arburst), .m_arlock(f_arlock), .m_arcache(f_arcache), .m_arprot(f_arprot),
      .m_arvalid(f_arvalid), .m_arready(m_arready),
      .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
      .m_rvalid(m_rvalid), .m_rready(f_rready),
      .m_awid(f_awid), .m_awaddr(f_awaddr), .m_awlen(f_awlen), .m_awsize(f_awsize),
      .m_awburst(f_awburst), .m_awlock(f_awlock), .m_awcache(f_awcache), .m_awprot(f_awprot),
      .m_awvalid(f_awvalid), .m_awready(m_awready),
      .m_wid(f_wid), .m_wdata(f_wdata), .m_wstrb(f_wstrb), .m_wlast(f_wlast),
      .m_wvalid(f_wvalid), .m_wready(m_wready),
      .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(f_bready)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Inputs change 1ns after the rising edge; outputs are checked on the falling edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic setp(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d = 32'h0, input logic [3:0] s = 4'hf);
      req[p]            = r;
      wr[p]             = w;
      addr[p*32 +: 32]  = a;
      wdata[p*32 +: 32] = d;
      wstrb[p*4 +: 4]   = s;
      size[p*2 +: 2]    = SIZE_WORD;
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] wr;
      logic [N-1:0] exp_rr;
      logic [N-1:0] exp_fx;
   } vec_t;

   vec_t vt[7];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
      m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b1; m_rid = '0; m_rdata = '0; m_rresp = '0;
      m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;

      // Grant table from the idle state (RR pointer at 0); requests are pulled
      // before the next edge so no grant is ever taken.
      vt[0] = '{req: 2'b00, wr: 2'b00, exp_rr: 2'b00, exp_fx: 2'b00};
      vt[1] = '{req: 2'b01, wr: 2'b00, exp_rr: 2'b01, exp_fx: 2'b01};
      vt[2] = '{req: 2'b10, wr: 2'b00, exp_rr: 2'b10, exp_fx: 2'b10};
      vt[3] = '{req: 2'b11, wr: 2'b00, exp_rr: 2'b01, exp_fx: 2'b01};
      vt[4] = '{req: 2'b11, wr: 2'b11, exp_rr: 2'b01, exp_fx: 2'b01};
      vt[5] = '{req: 2'b10, wr: 2'b10, exp_rr: 2'b10, exp_fx: 2'b10};
      vt[6] = '{req: 2'b11, wr: 2'b10, exp_rr: 2'b01, exp_fx: 2'b01};

      // Reset state and constant AXI fields
      #2;
      chk("rst addr_ok", addr_ok, 0);
      chk("rst data_ok", data_ok, 0);
      chk("rst rdata", srdata, 0);
      chk("rst arvalid", m_arvalid, 0);
      chk("rst awvalid", m_awvalid, 0);
      chk("rst wvalid", m_wvalid, 0);
      chk("const arlen", m_arlen, 0);
      chk("const arburst", m_arburst, 1);
      chk("const rready", m_rready, 1);
      chk("const bready", m_bready, 1);
      chk("const wlast", m_wlast, 1);
      @(posedge clk);
      #1 rst_n = 1'b1;

      setp(0, 1'b0, 1'b0, 32'h100);
      setp(1, 1'b0, 1'b0, 32'h200);
      for (int i = 0; i < 7; i++) begin
         tick();
         req = vt[i].req;
         wr  = vt[i].wr;
         settle();
         chk($sformatf("tbl%0d rr addr_ok", i), addr_ok, vt[i].exp_rr);
         chk($sformatf("tbl%0d fx addr_ok", i), f_addr_ok, vt[i].exp_fx);
         #1;
         req = '0;
         wr  = '0;
      end

      // Single read: addr_ok c0, AR c1, R c2, data_ok c3
      tick(); setp(0, 1'b1, 1'b0, 32'h1c00_0000); settle();
      chk("rd1 addr_ok", addr_ok, 2'b01);
      tick(); req = '0; settle();
      chk("rd1 arvalid", m_arvalid, 1);
      chk("rd1 arid", m_arid, 0);
      chk("rd1 araddr", m_araddr, 32'h1c00_0000);
      chk("rd1 arsize", m_arsize, 3'd2);
      tick(); m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'hdead_beef; settle();
      chk("rd1 arvalid drop", m_arvalid, 0);
      chk("rd1 no early data_ok", data_ok, 0);
      tick(); m_rvalid = 1'b0; settle();
      chk("rd1 data_ok", data_ok, 2'b01);
      chk("rd1 rdata", srdata[31:0], 32'hdead_beef);
      tick(); settle();
      chk("rd1 data_ok pulse", data_ok, 0);

      // Response for a non-busy id is dropped
      tick(); m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = 32'h0000_0bad; settle();
      tick(); m_rvalid = 1'b0; settle();
      chk("stray data_ok", data_ok, 0);
      chk("stray rdata1", srdata[63:32], 0);

      // Both ports read continuously; RR pointer sits at 1 after the port-0 read
      tick(); setp(0, 1'b1, 1'b0, 32'h100); setp(1, 1'b1, 1'b0, 32'h200); settle();
      chk("cc rr grant1", addr_ok, 2'b10);
      chk("cc fx grant0", f_addr_ok, 2'b01);
      tick(); settle();
      chk("cc rr hold", addr_ok, 2'b00);
      chk("cc fx hold", f_addr_ok, 2'b00);
      chk("cc arid1", m_arid, 1);
      chk("cc araddr1", m_araddr, 32'h200);
      tick(); settle();
      chk("cc rr grant0", addr_ok, 2'b01);
      chk("cc fx grant1 only when p0 busy", f_addr_ok, 2'b10);
      tick(); req = '0; settle();
      chk("cc arid0", m_arid, 0);
      chk("cc araddr0", m_araddr, 32'h100);
      chk("cc arvalid", m_arvalid, 1);
      tick(); m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = 32'h1111_2222; settle();
      tick(); m_rid = 4'd0; m_rdata = 32'h3333_4444; settle();
      chk("cc data_ok p1", data_ok, 2'b10);
      chk("cc rdata p1", srdata[63:32], 32'h1111_2222);
      chk("cc fx data_ok p1", f_data_ok, 2'b10);
      tick(); m_rvalid = 1'b0; settle();
      chk("cc data_ok p0", data_ok, 2'b01);
      chk("cc rdata p0", srdata[31:0], 32'h3333_4444);
      chk("cc rdata p1 kept", srdata[63:32], 32'h1111_2222);

      // Write then same-word read: read withheld until after B
      tick(); setp(1, 1'b1, 1'b1, 32'h1000, 32'ha5a5_a5a5, 4'hf); settle();
      chk("wr addr_ok", addr_ok, 2'b10);
      tick(); setp(1, 1'b0, 1'b0, 32'h1000); setp(0, 1'b1, 1'b0, 32'h1000); settle();
      chk("wr awvalid", m_awvalid, 1);
      chk("wr wvalid", m_wvalid, 1);
      chk("wr awid", m_awid, 1);
      chk("wr wid", m_wid, 1);
      chk("wr awaddr", m_awaddr, 32'h1000);
      chk("wr wdata", m_wdata, 32'ha5a5_a5a5);
      chk("wr wstrb", m_wstrb, 4'hf);
      chk("wr awlen", m_awlen, 0);
      chk("wr awburst", m_awburst, 1);
      chk("haz blocked W_ADDR", addr_ok, 2'b00);
      tick(); settle();
      chk("wr valids dropped", {m_awvalid, m_wvalid}, 2'b00);
      chk("haz blocked W_RESP", addr_ok, 2'b00);
      tick(); m_bvalid = 1'b1; m_bid = 4'd1; settle();
      chk("haz blocked on B", addr_ok, 2'b00);
      tick(); m_bvalid = 1'b0; settle();
      chk("haz released", addr_ok, 2'b01);
      chk("wr data_ok", data_ok, 2'b10);
      tick(); req = '0; settle();
      chk("haz arvalid", m_arvalid, 1);
      chk("haz araddr", m_araddr, 32'h1000);
      chk("wr data_ok single", data_ok, 0);
      tick(); m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'ha5a5_a5a5; settle();
      tick(); m_rvalid = 1'b0; settle();
      chk("haz rd data_ok", data_ok, 2'b01);
      chk("haz rd rdata", srdata[31:0], 32'ha5a5_a5a5);

      // Independent AW/W handshakes: awready late, wready immediate
      tick(); m_awready = 1'b0; setp(1, 1'b1, 1'b1, 32'h2000, 32'h1234_5678, 4'h3); settle();
      chk("aw addr_ok", addr_ok, 2'b10);
      tick(); req = '0; settle();
      chk("aw c1 valids", {m_awvalid, m_wvalid}, 2'b11);
      chk("aw wstrb", m_wstrb, 4'h3);
      tick(); settle();
      chk("aw c2 valids", {m_awvalid, m_wvalid}, 2'b10);
      chk("aw c2 awaddr", m_awaddr, 32'h2000);
      tick(); m_awready = 1'b1; settle();
      chk("aw c3 valids", {m_awvalid, m_wvalid}, 2'b10);
      chk("aw c3 data_ok", data_ok, 0);
      tick(); settle();
      chk("aw c4 valids", {m_awvalid, m_wvalid}, 2'b00);
      tick(); m_bvalid = 1'b1; settle();
      chk("aw B data_ok", data_ok, 0);
      tick(); m_bvalid = 1'b0; settle();
      chk("aw data_ok", data_ok, 2'b10);
      tick(); settle();
      chk("aw data_ok once", data_ok, 0);

      // Reset mid-read with AR stalled, then a fresh read
      tick(); m_arready = 1'b0; setp(0, 1'b1, 1'b0, 32'h3000); settle();
      chk("rm addr_ok", addr_ok, 2'b01);
      tick(); settle();
      chk("rm arvalid", m_arvalid, 1);
      tick(); settle();
      chk("rm arvalid held", m_arvalid, 1);
      chk("rm araddr held", m_araddr, 32'h3000);
      #1 rst_n = 1'b0;
      #1;
      chk("rm arvalid rst", m_arvalid, 0);
      chk("rm addr_ok rst", addr_ok, 0);
      chk("rm data_ok rst", data_ok, 0);
      chk("rm rdata rst", srdata, 0);
      chk("rm aw/w rst", {m_awvalid, m_wvalid}, 2'b00);
      req = '0;
      m_arready = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick(); setp(0, 1'b1, 1'b0, 32'h4000); settle();
      chk("post addr_ok", addr_ok, 2'b01);
      tick(); req = '0; settle();
      chk("post arvalid", m_arvalid, 1);
      chk("post araddr", m_araddr, 32'h4000);
      tick(); m_rvalid = 1'b1; m_rid = 4'd0; m_rdata = 32'hcafe_f00d; settle();
      tick(); m_rvalid = 1'b0; settle();
      chk("post data_ok", data_ok, 2'b01);
      chk("post rdata", srdata[31:0], 32'hcafe_f00d);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sram_axi_bridge_n.md
Name: sram_axi_bridge_n

Overview:
- Parametrised successor to the two-port SRAM-to-AXI bridge.
- Arbitrates NUM_PORTS SRAM-like masters (inst, data, future ports) onto one AXI3 master interface.
- Supports one outstanding read per port concurrently with one write, with same-word hazard blocking and selectable fixed or round-robin arbitration.
- Sits between the CPU core and the AXI interconnect at mycpu top level.

Parameters:
- NUM_PORTS, 2, number of SRAM-like ports (1..8); port p uses AXI ID p.
- ARB_MODE, 1, 0 = fixed priority (port 0 highest), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sram_req  in  NUM_PORTS  request per port
- sram_wr  in  NUM_PORTS  1 = write
- sram_size  in  2*NUM_PORTS  0 = byte, 1 = half, 2 = word
- sram_wstrb  in  4*NUM_PORTS  byte strobes
- sram_addr  in  32*NUM_PORTS  byte address
- sram_wdata  in  32*NUM_PORTS  write data
- sram_addr_ok  out  NUM_PORTS  request accepted this cycle
- sram_data_ok  out  NUM_PORTS  read data valid / write complete pulse
- sram_rdata  out  32*NUM_PORTS  read data
- m_ar* (arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid out; arready in): AXI3 AR
- m_r* (rid 4, rdata 32, rresp 2, rlast 1, rvalid in; rready out): AXI3 R
- m_aw* (same widths as AR): AXI3 AW
- m_w* (wid 4, wdata 32, wstrb 4, wlast 1, wvalid out; wready in): AXI3 W
- m_b* (bid 4, bresp 2, bvalid in; bready out): AXI3 B

Behaviour:
- Reset (async, rst_n=0): all addr_ok/data_ok/arvalid/awvalid/wvalid=0, rdata=0, rd_busy=0, write FSM=W_IDLE, RR pointer=0. Outstanding transactions are dropped; AXI responses arriving after reset are ignored by the bench.
- Constants: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1, a*size={1'b0,size}, rready=1 and bready=1 always.
- Per-port read state: rd_busy[p], rd_addr[p] (word address).
- Write FSM: W_IDLE -> W_ADDR (awvalid and wvalid both raised) -> each valid drops independently on its handshake -> W_RESP when both done -> W_IDLE on bvalid. Records owner port and word address.
- Read eligible(p): req[p] & !wr[p] & !rd_busy[p] & !m_arvalid & !(write FSM != W_IDLE & word addr == write word addr).
- Write eligible(p): req[p] & wr[p] & write FSM == W_IDLE & no rd_busy[q] with rd_addr[q] == addr[p][31:2].
- One grant per cycle among eligible ports per ARB_MODE. addr_ok[g] is combinational, same cycle as the grant.
- RR pointer moves to g+1 mod NUM_PORTS on a grant and is unchanged otherwise.
- Read grant: next cycle arvalid=1, arid=g, araddr=addr[g]; rd_busy[g] set. arvalid is held stable until arready, then drops.
- Read response: on rvalid with rid=p, rdata[p] is registered and data_ok[p] pulses the following cycle; rd_busy[p] clears the same edge. Minimum read latency from addr_ok is 3 cycles (AR, R, data_ok).
- Write grant: awid=wid=g, awaddr, wdata, wstrb latched. data_ok[owner] pulses the cycle after the bvalid handshake.
- A port may get addr_ok and data_ok in the same cycle.
- rresp/bresp are ignored. An rvalid with rid not busy is consumed and dropped.
- data_ok is never asserted without a prior addr_ok on that port.

Decomposition:
- Shared package: AXI constants (BURST_INCR, LEN_SINGLE), size encodings, ARB_FIXED/ARB_RR, write FSM state encoding.
- Sub-module sram_axi_arbiter: request vector + mode + pointer in, one-hot grant out. Purely combinational, with the pointer register held in the parent.

Test Plan:
- Single read: port 0 reads 0x1c000000 word; arready=1, rvalid next cycle with rdata=0xdeadbeef -> addr_ok cycle 0, arvalid cycle 1 with arid=0, data_ok[0] cycle 3 with rdata=0xdeadbeef.
- Concurrent reads: ports 0 and 1 request on the same cycle, ARB_MODE=1. R returns rid=1 before rid=0 -> ports are granted in RR order on consecutive free-AR cycles, and each port gets its own data with no cross-routing.
- Fixed priority: ARB_MODE=0, ports 0 and 1 request continuously -> port 1 is granted only on cycles where port 0 is ineligible (rd_busy[0]=1).
- Write then same-address read: port 1 writes 0xa5a5a5a5 to 0x1000 with wstrb=4'hf; port 0 reads 0x1000 while awaiting B -> read addr_ok is withheld until the cycle after the bvalid handshake.
- Independent AW/W: awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid holds until awready, and exactly one data_ok[1] pulse follows B.
- Reset mid-read: rst_n deasserted while rd_busy[0]=1 and arvalid=1 -> all outputs 0 immediately. After release, a fresh read completes normally.
